// File: rtl/hlsm_job_dispatcher_pkg.sv
// Shared types for the HLSM job dispatcher: FSM states, error codes, operand tuple.
package hlsm_job_dispatcher_pkg;

  localparam int OP_W = 65;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    RESULT
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [OP_W-1:0] c;
    logic [OP_W-1:0] d;
    logic [OP_W-1:0] zero;
  } operand_t;

endpackage

// File: rtl/hlsm_job_dispatcher_job_fifo.sv
// Synchronous FIFO of operand tuples; full/empty derive from a registered occupancy count.
module hlsm_job_dispatcher_job_fifo
  import hlsm_job_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  operand_t i_data,
  input  logic     i_pop,
  output operand_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  operand_t       r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/hlsm_job_dispatcher.sv
// Feeds operand tuples to the divide/modulo/select HLSM one job at a time, holding Start until Done,
// with stale-Done guard, divide-by-zero screening and a run timeout.
module hlsm_job_dispatcher
  import hlsm_job_dispatcher_pkg::*;
#(
  parameter int DATA_W      = OP_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int DONE_GUARD  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_a,
  input  logic [DATA_W-1:0] i_in_b,
  input  logic [DATA_W-1:0] i_in_c,
  input  logic [DATA_W-1:0] i_in_d,
  input  logic [DATA_W-1:0] i_in_zero,
  output logic              o_hlsm_rst,
  output logic              o_hlsm_start,
  output logic [DATA_W-1:0] o_hlsm_a,
  output logic [DATA_W-1:0] o_hlsm_b,
  output logic [DATA_W-1:0] o_hlsm_c,
  output logic [DATA_W-1:0] o_hlsm_d,
  output logic [DATA_W-1:0] o_hlsm_zero,
  input  logic              i_hlsm_done,
  input  logic [DATA_W-1:0] i_hlsm_z,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_z,
  output logic [1:0]        o_out_err
);

  localparam int GW = $clog2(DONE_GUARD + 2);
  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t            r_state;
  operand_t          r_op;
  logic [GW-1:0]     r_guard;
  logic [TW-1:0]     r_tmo;
  logic              r_start;
  logic              r_hlsm_rst;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_z;
  logic [1:0]        r_out_err;

  operand_t w_in_op;
  operand_t w_fifo_op;
  logic     w_full;
  logic     w_empty;
  logic     w_push;
  logic     w_pop;
  logic     w_guard_ok;
  logic     w_done_acc;
  logic     w_tmo;

  assign w_in_op = '{a: i_in_a, b: i_in_b, c: i_in_c, d: i_in_d, zero: i_in_zero};
  assign w_push  = i_in_valid && !w_full;
  assign w_pop   = (r_state == IDLE) && !w_empty;

  hlsm_job_dispatcher_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_in_op),
    .i_pop   (w_pop),
    .o_data  (w_fifo_op),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_guard_ok = (r_guard >= GW'(DONE_GUARD));
  assign w_done_acc = (r_state == RUN) && w_guard_ok && i_hlsm_done;
  assign w_tmo      = (r_state == RUN) && (r_tmo == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_guard     <= '0;
      r_tmo       <= '0;
      r_start     <= 1'b0;
      r_hlsm_rst  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_err   <= ERR_OK;
    end else begin
      r_hlsm_rst <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_op    <= w_fifo_op;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (r_op.b == '0 || r_op.d == '0) begin
            r_out_z     <= '0;
            r_out_err   <= ERR_DIV0;
            r_out_valid <= 1'b1;
            r_state     <= RESULT;
          end else begin
            r_guard <= '0;
            r_tmo   <= '0;
            r_start <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_done_acc) begin
            r_start     <= 1'b0;
            r_out_z     <= i_hlsm_z;
            r_out_err   <= ERR_OK;
            r_out_valid <= 1'b1;
            r_state     <= RESULT;
          end else if (w_tmo) begin
            r_start     <= 1'b0;
            r_hlsm_rst  <= 1'b1;
            r_out_z     <= '0;
            r_out_err   <= ERR_TMO;
            r_out_valid <= 1'b1;
            r_state     <= RESULT;
          end else begin
            if (!w_guard_ok) r_guard <= r_guard + 1'b1;
            r_tmo <= r_tmo + 1'b1;
          end
        end
        RESULT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Start drops in the accepting cycle so the HLSM, back in its start state, does not relaunch.
  assign o_hlsm_start = r_start && !w_done_acc;
  assign o_hlsm_rst   = r_hlsm_rst;
  assign o_hlsm_a     = r_op.a;
  assign o_hlsm_b     = r_op.b;
  assign o_hlsm_c     = r_op.c;
  assign o_hlsm_d     = r_op.d;
  assign o_hlsm_zero  = r_op.zero;
  assign o_in_ready   = !w_full;
  assign o_out_valid  = r_out_valid;
  assign o_out_z      = r_out_z;
  assign o_out_err    = r_out_err;

endmodule

// File: tb/tb_hlsm_job_dispatcher.sv
// Scoreboard bench for hlsm_job_dispatcher with a behavioural HLSM attached.
module tb_hlsm_job_dispatcher;

  localparam int W = 65;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         o_in_ready;
  logic [W-1:0] in_a, in_b, in_c, in_d, in_zero;
  logic         o_hlsm_rst, o_hlsm_start;
  logic [W-1:0] o_hlsm_a, o_hlsm_b, o_hlsm_c, o_hlsm_d, o_hlsm_zero;
  logic         m_done = 1'b0;
  logic [W-1:0] m_z = '0;
  logic         o_out_valid;
  logic         out_ready;
  logic [W-1:0] o_out_z;
  logic [1:0]   o_out_err;

  always #5 clk = ~clk;

  hlsm_job_dispatcher #(
    .DATA_W(W), .FIFO_DEPTH(4), .DONE_GUARD(2), .TIMEOUT_CYC(64)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_c(in_c), .i_in_d(in_d), .i_in_zero(in_zero),
    .o_hlsm_rst(o_hlsm_rst), .o_hlsm_start(o_hlsm_start),
    .o_hlsm_a(o_hlsm_a), .o_hlsm_b(o_hlsm_b), .o_hlsm_c(o_hlsm_c), .o_hlsm_d(o_hlsm_d),
    .o_hlsm_zero(o_hlsm_zero),
    .i_hlsm_done(m_done), .i_hlsm_z(m_z),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready),
    .o_out_z(o_out_z), .o_out_err(o_out_err)
  );

  typedef struct {
    logic [W-1:0] z;
    logic [1:0]   err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int rst_cyc = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // HLSM model: wait for Start, compute after m_lat cycles, hold Done for m_hold+1 cycles.
  int m_state = 0;
  int m_cnt = 0;
  int m_hcnt = 0;
  int m_lat = 3;
  int m_hold = 0;
  bit m_never = 1'b0;
  bit m_fresh = 1'b0;

  always @(posedge clk) begin
    m_fresh <= 1'b0;
    if (rst || o_hlsm_rst) begin
      m_state <= 0;
      m_done  <= 1'b0;
    end else begin
      case (m_state)
        0: if (o_hlsm_start) begin
             m_state <= 1;
             m_cnt   <= m_lat;
           end
        1: if (!m_never) begin
             if (m_cnt == 0) begin
               m_done  <= 1'b1;
               m_z     <= ((o_hlsm_a % o_hlsm_b) == o_hlsm_zero) ? (o_hlsm_a / o_hlsm_b)
                                                                  : (o_hlsm_c / o_hlsm_d);
               m_hcnt  <= m_hold;
               m_fresh <= 1'b1;
               m_state <= 2;
             end else begin
               m_cnt <= m_cnt - 1;
             end
           end
        default: if (m_hcnt == 0) begin
             m_state <= 0;
             m_done  <= 1'b0;
           end else begin
             m_hcnt <= m_hcnt - 1;
           end
      endcase
    end
  end

  // Monitor: compares every presented result against the queue head; pops on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_hlsm_start) start_cyc++;
      if (o_hlsm_rst) rst_cyc++;
      if (m_fresh) chk("start_low_on_done", o_hlsm_start, 0);
      if (o_out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual z=%0h err=%0h required none", o_out_z, o_out_err);
        end else begin
          chk("out_z", o_out_z, q[0].z);
          chk("out_err", o_out_err, q[0].err);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [W-1:0] d, input logic [W-1:0] zero,
                      input logic [W-1:0] ez, input logic [1:0] eerr);
    int t = 0;
    while (!o_in_ready && t < 300) begin
      step(1);
      t++;
    end
    chk("push_ready", o_in_ready, 1);
    in_a = a; in_b = b; in_c = c; in_d = d; in_zero = zero;
    in_valid = 1'b1;
    q.push_back('{z: ez, err: eerr});
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 1000) begin
      step(1);
      t++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic wait_start();
    int t = 0;
    while (!o_hlsm_start && t < 100) begin
      step(1);
      t++;
    end
    chk("start_seen", o_hlsm_start, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int r0;
    int t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_zero = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_start", o_hlsm_start, 0);
    chk("rst_hlsm_rst", o_hlsm_rst, 0);
    chk("rst_out_err", o_out_err, 0);
    rst = 1'b0;
    step(1);

    // single job: 10%3==1 selects 10/3
    push(10, 3, 20, 4, 1, 3, 2'b00);
    wait_start();
    chk("hlsm_a", o_hlsm_a, 10);
    chk("hlsm_b", o_hlsm_b, 3);
    drain();

    // select path: 9%3==0 != 1 selects 20/4
    push(9, 3, 20, 4, 1, 5, 2'b00);
    drain();

    // divide-by-zero on b and on d; HLSM must never start
    s0 = start_cyc;
    push(5, 0, 6, 2, 0, 0, 2'b01);
    push(5, 1, 6, 0, 0, 0, 2'b01);
    drain();
    chk("div0_no_start", start_cyc - s0, 0);

    // b nonzero only in bit 64: full-width zero compare
    push(65'h1_0000_0000_0000_0000, 65'h1_0000_0000_0000_0000, 8, 2, 0, 1, 2'b00);
    drain();

    // stale Done overlapping the guard window, FIFO filled to 4
    m_hold = 5;
    push(9, 3, 20, 4, 1, 5, 2'b00);
    push(100, 7, 0, 1, 2, 14, 2'b00);
    push(50, 5, 81, 9, 1, 9, 2'b00);
    push(17, 4, 1, 1, 1, 4, 2'b00);
    push(44, 2, 30, 6, 0, 22, 2'b00);
    chk("full_in_ready", o_in_ready, 0);
    drain();
    step(8);
    m_hold = 0;

    // timeout then a normal job
    m_never = 1'b1;
    s0 = start_cyc;
    r0 = rst_cyc;
    push(30, 5, 1, 1, 3, 0, 2'b10);
    drain();
    chk("tmo_start_cycles", start_cyc - s0, 64);
    chk("tmo_rst_pulses", rst_cyc - r0, 1);
    m_never = 1'b0;
    step(2);
    push(12, 5, 7, 7, 2, 2, 2'b00);
    drain();

    // backpressure: result held while out_ready low
    out_ready = 1'b0;
    push(7, 2, 9, 3, 1, 3, 2'b00);
    t = 0;
    while (!o_out_valid && t < 100) begin
      step(1);
      t++;
    end
    step(10);
    chk("bp_valid_held", o_out_valid, 1);
    out_ready = 1'b1;
    drain();

    // reset mid-RUN discards everything
    m_never = 1'b1;
    push(40, 4, 1, 1, 0, 10, 2'b00);
    push(41, 4, 1, 1, 0, 1, 2'b00);
    wait_start();
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_start", o_hlsm_start, 0);
    chk("mid_rst_valid", o_out_valid, 0);
    chk("mid_rst_out_z", o_out_z, 0);
    chk("mid_rst_err", o_out_err, 0);
    chk("mid_rst_hlsm_a", o_hlsm_a, 0);
    chk("mid_rst_hlsm_rst", o_hlsm_rst, 0);
    chk("mid_rst_in_ready", o_in_ready, 1);
    step(1);
    rst = 1'b0;
    m_never = 1'b0;
    s0 = start_cyc;
    step(10);
    chk("post_rst_fifo_empty", start_cyc - s0, 0);
    chk("post_rst_valid", o_out_valid, 0);
    push(9, 3, 20, 4, 1, 5, 2'b00);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
